// File: rtl/btn_debounce.sv
// Purpose: two-flop synchroniser plus per-channel counter debounce for push buttons, with press/release strobes.
// Latency: a new stable input level is accepted on the (DEB_CYCLES+2)th rising edge that samples it.
// Backpressure: none; strobes last one cycle and are never held or queued.
module btn_debounce #(
  parameter int NB_SW      = 4,
  parameter int NB_DEB     = 16,
  parameter int DEB_CYCLES = 10000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_btn,
  output logic [NB_SW-1:0] o_btn_level,
  output logic [NB_SW-1:0] o_btn_pulse,
  output logic [NB_SW-1:0] o_btn_release
);

  // Terminal count: a mismatch seen while the counter already holds this value is accepted.
  localparam logic [NB_DEB-1:0] CNT_LAST = NB_DEB'(DEB_CYCLES - 1);
  localparam logic [NB_DEB-1:0] CNT_ONE  = NB_DEB'(1);

  logic [NB_SW-1:0]             sync1_q, sync1_d;
  logic [NB_SW-1:0]             sync2_q, sync2_d;
  logic [NB_SW-1:0]             level_q, level_d;
  logic [NB_SW-1:0]             pulse_q, pulse_d;
  logic [NB_SW-1:0]             release_q, release_d;
  logic [NB_SW-1:0][NB_DEB-1:0] cnt_q, cnt_d;

  // Next-state: shift the synchroniser and run each channel's debounce counter independently.
  always_comb begin
    sync1_d   = i_btn;
    sync2_d   = sync1_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    pulse_d   = '0;
    release_d = '0;
    for (int k = 0; k < NB_SW; k++) begin
      if (sync2_q[k] == level_q[k]) begin
        // Agreement (or a glitch that returned before acceptance) restarts the count.
        cnt_d[k] = '0;
      end else if (cnt_q[k] >= CNT_LAST) begin
        // Accept the new level; the strobe is registered on the same edge as the level.
        level_d[k]   = sync2_q[k];
        cnt_d[k]     = '0;
        pulse_d[k]   = sync2_q[k];
        release_d[k] = ~sync2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_ONE;
      end
    end
  end

  // State registers; reset clears everything so a held button is re-debounced afterwards.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      pulse_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
    end
  end

  assign o_btn_level   = level_q;
  assign o_btn_pulse   = pulse_q;
  assign o_btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEB_CYCLES=4 and four channels.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after a rising edge.
// Expected values are hand-derived: a new stable level is accepted on the 6th edge.
module tb_btn_debounce;

  logic       clock;
  logic       i_reset;
  logic [3:0] i_btn;
  logic [3:0] o_btn_level;
  logic [3:0] o_btn_pulse;
  logic [3:0] o_btn_release;

  int checks;
  int failures;

  btn_debounce #(
    .NB_SW     (4),
    .NB_DEB    (16),
    .DEB_CYCLES(4)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_btn        (i_btn),
    .o_btn_level  (o_btn_level),
    .o_btn_pulse  (o_btn_pulse),
    .o_btn_release(o_btn_release)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expect quiet strobes for n edges with a fixed level.
  task automatic quiet(input string tag, input int n, input logic [3:0] lvl);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_pulse"}, o_btn_pulse, 4'b0000);
      check({tag, "_release"}, o_btn_release, 4'b0000);
      check({tag, "_level"}, o_btn_level, lvl);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_reset  = 1'b1;
    i_btn    = 4'b1111;

    // 1: reset with all buttons held
    #1;
    check("rst_level", o_btn_level, 4'b0000);
    check("rst_pulse", o_btn_pulse, 4'b0000);
    check("rst_release", o_btn_release, 4'b0000);
    tick();
    tick();
    check("rst_level_held", o_btn_level, 4'b0000);
    check("rst_pulse_held", o_btn_pulse, 4'b0000);
    i_reset = 1'b0;
    quiet("t1_wait", 5, 4'b0000);
    tick();
    check("t1_pulse", o_btn_pulse, 4'b1111);
    check("t1_level", o_btn_level, 4'b1111);
    check("t1_release", o_btn_release, 4'b0000);
    tick();
    check("t1_pulse_once", o_btn_pulse, 4'b0000);
    check("t1_level_hold", o_btn_level, 4'b1111);

    // release everything to get a clean baseline (symmetric release path)
    i_btn = 4'b0000;
    quiet("base_wait", 5, 4'b1111);
    tick();
    check("base_release", o_btn_release, 4'b1111);
    check("base_level", o_btn_level, 4'b0000);
    check("base_pulse", o_btn_pulse, 4'b0000);
    tick();
    check("base_release_once", o_btn_release, 4'b0000);

    // 2: clean press on bit 0, held 200 ns
    i_btn = 4'b0001;
    quiet("t2_wait", 5, 4'b0000);
    tick();
    check("t2_pulse", o_btn_pulse, 4'b0001);
    check("t2_level", o_btn_level, 4'b0001);
    quiet("t2_held", 14, 4'b0001);

    // 3: bounce on bit 1, then stay pressed
    i_btn[1] = 1'b1; tick();
    check("t3_b1", o_btn_pulse, 4'b0000);
    i_btn[1] = 1'b0; tick();
    check("t3_b2", o_btn_pulse, 4'b0000);
    i_btn[1] = 1'b1; tick();
    check("t3_b3", o_btn_pulse, 4'b0000);
    i_btn[1] = 1'b0; tick();
    check("t3_b4", o_btn_pulse, 4'b0000);
    i_btn[1] = 1'b1;
    quiet("t3_wait", 5, 4'b0001);
    tick();
    check("t3_pulse", o_btn_pulse, 4'b0010);
    check("t3_level", o_btn_level, 4'b0011);
    tick();
    check("t3_pulse_once", o_btn_pulse, 4'b0000);

    // 4: 30 ns glitch on bit 2, one edge short of acceptance
    i_btn[2] = 1'b1;
    tick();
    tick();
    tick();
    i_btn[2] = 1'b0;
    quiet("t4_glitch", 8, 4'b0011);

    // 5: release bit 0
    i_btn[0] = 1'b0;
    quiet("t5_wait", 5, 4'b0011);
    tick();
    check("t5_release", o_btn_release, 4'b0001);
    check("t5_level", o_btn_level, 4'b0010);
    check("t5_pulse", o_btn_pulse, 4'b0000);
    tick();
    check("t5_release_once", o_btn_release, 4'b0000);

    // 6a: simultaneous press of bits 0 and 3
    i_btn = 4'b1011;
    quiet("t6a_wait", 5, 4'b0010);
    tick();
    check("t6a_pulse", o_btn_pulse, 4'b1001);
    check("t6a_level", o_btn_level, 4'b1011);
    tick();
    check("t6a_pulse_once", o_btn_pulse, 4'b0000);

    // 6b: press bit 2, reset at the 3rd edge mid-count
    i_btn = 4'b1111;
    quiet("t6b_count", 3, 4'b1011);
    i_reset = 1'b1;
    #1;
    check("t6b_rst_level", o_btn_level, 4'b0000);
    check("t6b_rst_pulse", o_btn_pulse, 4'b0000);
    check("t6b_rst_release", o_btn_release, 4'b0000);
    quiet("t6b_in_rst", 2, 4'b0000);
    i_reset = 1'b0;
    quiet("t6b_redeb", 5, 4'b0000);
    tick();
    check("t6b_pulse", o_btn_pulse, 4'b1111);
    check("t6b_level", o_btn_level, 4'b1111);
    check("t6b_release", o_btn_release, 4'b0000);
    tick();
    check("t6b_pulse_once", o_btn_pulse, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
